// File: rtl/ime_log2_arb_pkg.sv
// Shared types and constants for the log2-adapt arbiter: FSM state
// encoding, id-width helper and the field values of a watchdog flush beat.
package ime_log2_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK  = 2'd1,
        FLUSH = 2'd2
    } arb_state_e;

    // Width of a requester index: $clog2(n), never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int          TUSER_W       = 8;
    localparam int          FLUSH_CNT_W   = 16;
    localparam logic [15:0] FLUSH_CNT_MAX = 16'hFFFF;

    // A flush beat carries zeroed probabilities/score and closes the packet
    // as poisoned so the adapt stage discards it.
    localparam logic FLUSH_FILL   = 1'b0;
    localparam logic FLUSH_LAST   = 1'b1;
    localparam logic FLUSH_POISON = 1'b1;

endpackage

// File: rtl/ime_rr_pick.sv
// Combinational round-robin picker: first set bit of req at or above ptr,
// wrapping around to index 0.
module ime_rr_pick
    import ime_log2_arb_pkg::*;
#(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [ID_W-1:0] winner,
    output logic            found
);

    int idx;

    // Scan offsets 0..N-1 from the pointer and keep the first hit.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise a path that skips the assignment infers a latch.
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                winner = ID_W'(idx);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ime_log2_arb.sv
// Packet-locking round-robin arbiter feeding the log2 adapt stage through a
// single output register slice. The idle watchdog, which flushes a stalled
// packet with a poisoned last beat, is built only when
// IME_LOG2_ARB_WATCHDOG_EN is defined.
module ime_log2_arb
    import ime_log2_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int W_P   = 16,
    parameter int W_LOG = 16,
    parameter int W_TO  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*W_P-1:0]   req_prob_p,
    input  logic [N_REQ*W_P-1:0]   req_prob_q,
    input  logic [N_REQ*W_LOG-1:0] req_score,
    input  logic [N_REQ-1:0]       req_last,
    input  logic [N_REQ-1:0]       req_poison,
    input  logic [N_REQ-1:0]       req_enable,
    input  logic [W_TO-1:0]        timeout_cfg,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [W_P-1:0]         out_prob_p,
    output logic [W_P-1:0]         out_prob_q,
    output logic [W_LOG-1:0]       out_score,
    output logic [7:0]             out_tuser,
    output logic                   out_last,
    output logic                   out_poison,
    output logic [7:0]             grant_id,
    output logic                   busy,
    output logic [15:0]            flush_count
);

    localparam int ID_W = id_width(N_REQ);

    arb_state_e        state_q, state_d;
    logic [ID_W-1:0]   grant_q, grant_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   pick_id, sel_id;
    logic              pick_found, slot_free, wd_expire;
    logic              load_beat, load_flush;
    logic [N_REQ-1:0]  ready;

    logic              out_valid_q, out_valid_d;
    logic [W_P-1:0]    out_p_q, out_p_d, out_q_q, out_q_d;
    logic [W_LOG-1:0]  out_score_q, out_score_d;
    logic [ID_W-1:0]   out_id_q, out_id_d;
    logic              out_last_q, out_last_d, out_poison_q, out_poison_d;

    assign slot_free = !out_valid_q || out_ready;
    assign sel_id    = (state_q == LOCK) ? grant_q : pick_id;

    ime_rr_pick #(.N(N_REQ), .ID_W(ID_W)) u_pick (
        .req    (req_valid & req_enable),
        .ptr    (rr_ptr_q),
        .winner (pick_id),
        .found  (pick_found)
    );

    // Arbitration FSM: next state, grant/pointer update and accept strobes.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        ready      = '0;
        load_beat  = 1'b0;
        load_flush = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found && slot_free) begin
                    ready[pick_id] = 1'b1;
                    load_beat      = 1'b1;
                    rr_ptr_d       = (int'(pick_id) == N_REQ - 1) ? '0 : pick_id + ID_W'(1);
                    if (!req_last[pick_id]) begin
                        state_d = LOCK;
                        grant_d = pick_id;
                    end
                end
            end
            LOCK: begin
                if (wd_expire) begin
                    state_d = FLUSH;
                end else begin
                    // The locked requester owns the slot regardless of req_enable.
                    ready[grant_q] = slot_free;
                    if (slot_free && req_valid[grant_q]) begin
                        load_beat = 1'b1;
                        if (req_last[grant_q]) state_d = IDLE;
                    end
                end
            end
            FLUSH: begin
                if (slot_free) begin
                    load_flush = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready = rst ? '0 : ready;

    // Output slice: load a requester beat or a flush beat, else drain on ready.
    always_comb begin
        out_valid_d  = out_valid_q && !out_ready;
        out_p_d      = out_p_q;
        out_q_d      = out_q_q;
        out_score_d  = out_score_q;
        out_id_d     = out_id_q;
        out_last_d   = out_last_q;
        out_poison_d = out_poison_q;
        if (load_flush) begin
            out_valid_d  = 1'b1;
            out_p_d      = {W_P{FLUSH_FILL}};
            out_q_d      = {W_P{FLUSH_FILL}};
            out_score_d  = {W_LOG{FLUSH_FILL}};
            out_id_d     = grant_q;
            out_last_d   = FLUSH_LAST;
            out_poison_d = FLUSH_POISON;
        end else if (load_beat) begin
            out_valid_d  = 1'b1;
            out_p_d      = req_prob_p[int'(sel_id)*W_P +: W_P];
            out_q_d      = req_prob_q[int'(sel_id)*W_P +: W_P];
            out_score_d  = req_score[int'(sel_id)*W_LOG +: W_LOG];
            out_id_d     = sel_id;
            out_last_d   = req_last[sel_id];
            out_poison_d = req_poison[sel_id];
        end
    end

    // State, pointer and output-slice registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            rr_ptr_q     <= '0;
            out_valid_q  <= 1'b0;
            out_p_q      <= '0;
            out_q_q      <= '0;
            out_score_q  <= '0;
            out_id_q     <= '0;
            out_last_q   <= 1'b0;
            out_poison_q <= 1'b0;
        end else begin
            // NOTE: registers take non-blocking assignments so every flop
            // samples the pre-edge values regardless of statement order.
            state_q      <= state_d;
            grant_q      <= grant_d;
            rr_ptr_q     <= rr_ptr_d;
            out_valid_q  <= out_valid_d;
            out_p_q      <= out_p_d;
            out_q_q      <= out_q_d;
            out_score_q  <= out_score_d;
            out_id_q     <= out_id_d;
            out_last_q   <= out_last_d;
            out_poison_q <= out_poison_d;
        end
    end

`ifdef IME_LOG2_ARB_WATCHDOG_EN
    logic [W_TO-1:0]        idle_cnt_q, idle_cnt_d;
    logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    assign wd_expire = (state_q == LOCK) && (timeout_cfg != '0) && (idle_cnt_q == timeout_cfg);

    // Count idle cycles of the locked requester; any accepted beat restarts it.
    always_comb begin
        idle_cnt_d = idle_cnt_q;
        if (state_q != LOCK || load_beat) begin
            idle_cnt_d = '0;
        end else if (!req_valid[grant_q] && idle_cnt_q != '1) begin
            idle_cnt_d = idle_cnt_q + W_TO'(1);
        end
        flush_cnt_d = flush_cnt_q;
        if (load_flush && flush_cnt_q != FLUSH_CNT_MAX) flush_cnt_d = flush_cnt_q + 16'd1;
    end

    // Watchdog counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt_q  <= '0;
            flush_cnt_q <= '0;
        end else begin
            idle_cnt_q  <= idle_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign flush_count = flush_cnt_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^timeout_cfg;
    assign wd_expire      = 1'b0;
    assign flush_count    = '0;
`endif

    assign out_valid  = out_valid_q;
    assign out_prob_p = out_p_q;
    assign out_prob_q = out_q_q;
    assign out_score  = out_score_q;
    assign out_tuser  = 8'(out_id_q);
    assign out_last   = out_last_q;
    assign out_poison = out_poison_q;
    assign grant_id   = 8'(grant_q);
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ime_log2_arb.sv
// Self-checking bench for ime_log2_arb: directed scenarios plus randomized
// traffic checked every cycle against a packet-level reference model.
// Watchdog expectations follow IME_LOG2_ARB_WATCHDOG_EN.
module tb_ime_log2_arb;

    localparam int N     = 4;
    localparam int W_P   = 16;
    localparam int W_LOG = 16;
    localparam int W_TO  = 16;

`ifdef IME_LOG2_ARB_WATCHDOG_EN
    localparam bit WD_ON = 1'b1;
`else
    localparam bit WD_ON = 1'b0;
`endif

    logic               clk, rst;
    logic [N-1:0]       req_valid, req_ready, req_last, req_poison, req_enable;
    logic [N*W_P-1:0]   req_prob_p, req_prob_q;
    logic [N*W_LOG-1:0] req_score;
    logic [W_TO-1:0]    timeout_cfg;
    logic               out_valid, out_ready, out_last, out_poison, busy;
    logic [W_P-1:0]     out_prob_p, out_prob_q;
    logic [W_LOG-1:0]   out_score;
    logic [7:0]         out_tuser, grant_id;
    logic [15:0]        flush_count;

    ime_log2_arb #(.N_REQ(N), .W_P(W_P), .W_LOG(W_LOG), .W_TO(W_TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_prob_p(req_prob_p), .req_prob_q(req_prob_q), .req_score(req_score),
        .req_last(req_last), .req_poison(req_poison), .req_enable(req_enable),
        .timeout_cfg(timeout_cfg),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_prob_p(out_prob_p), .out_prob_q(out_prob_q), .out_score(out_score),
        .out_tuser(out_tuser), .out_last(out_last), .out_poison(out_poison),
        .grant_id(grant_id), .busy(busy), .flush_count(flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: phase 0 = no open packet, 1 = packet open, 2 = flush owed.
    int               m_phase, m_gid, m_ptr, m_idle, m_flushes, m_id;
    logic             m_ov, m_last, m_poison;
    logic [W_P-1:0]   m_p, m_q;
    logic [W_LOG-1:0] m_s;
    logic [N-1:0]     acc;

    task automatic model_reset();
        m_phase = 0; m_gid = 0; m_ptr = 0; m_idle = 0; m_flushes = 0;
        m_ov = 1'b0; m_p = '0; m_q = '0; m_s = '0; m_id = 0;
        m_last = 1'b0; m_poison = 1'b0;
    endtask

    task automatic load_from(input int i);
        m_ov     = 1'b1;
        m_p      = req_prob_p[i*W_P +: W_P];
        m_q      = req_prob_q[i*W_P +: W_P];
        m_s      = req_score[i*W_LOG +: W_LOG];
        m_id     = i;
        m_last   = req_last[i];
        m_poison = req_poison[i];
    endtask

    // One clock: compare registered outputs and this cycle's req_ready with
    // the model, advance the model across the edge, return at the next negedge.
    task automatic step();
        logic [N-1:0] er;
        bit           free, did_load;
        int           pick, idx;
        #1;
        check("out_valid", out_valid, m_ov);
        if (m_ov) begin
            check("out_prob_p", out_prob_p, m_p);
            check("out_prob_q", out_prob_q, m_q);
            check("out_score", out_score, m_s);
            check("out_tuser", out_tuser, m_id);
            check("out_last", out_last, m_last);
            check("out_poison", out_poison, m_poison);
        end
        check("busy", busy, (m_phase != 0));
        check("grant_id", grant_id, m_gid);
        check("flush_count", flush_count, m_flushes);
        check("ready_onehot", ($countones(req_ready) <= 1), 1);
        er = '0; did_load = 1'b0; free = !m_ov || out_ready;
        if (rst) begin
            model_reset();
        end else begin
            case (m_phase)
                0: begin
                    m_idle = 0;
                    pick = -1;
                    for (int k = 0; k < N; k++) begin
                        idx = (m_ptr + k) % N;
                        if (pick < 0 && req_valid[idx] && req_enable[idx]) pick = idx;
                    end
                    if (pick >= 0 && free) begin
                        er[pick] = 1'b1;
                        load_from(pick);
                        did_load = 1'b1;
                        m_ptr = (pick + 1) % N;
                        if (!req_last[pick]) begin
                            m_phase = 1;
                            m_gid = pick;
                        end
                    end
                end
                1: begin
                    if (WD_ON && timeout_cfg != 0 && m_idle == int'(timeout_cfg)) begin
                        m_phase = 2;
                    end else begin
                        er[m_gid] = free;
                        if (free && req_valid[m_gid]) begin
                            load_from(m_gid);
                            did_load = 1'b1;
                            m_idle = 0;
                            if (req_last[m_gid]) m_phase = 0;
                        end else if (!req_valid[m_gid]) begin
                            m_idle++;
                        end
                    end
                end
                default: begin
                    m_idle = 0;
                    if (free) begin
                        m_ov = 1'b1; m_p = '0; m_q = '0; m_s = '0;
                        m_id = m_gid; m_last = 1'b1; m_poison = 1'b1;
                        did_load = 1'b1;
                        if (m_flushes < 16'hFFFF) m_flushes++;
                        m_phase = 0;
                    end
                end
            endcase
            if (!did_load && out_ready) m_ov = 1'b0;
        end
        check("req_ready", req_ready, er);
        acc = er & req_valid;
        @(negedge clk);
    endtask

    function automatic int oh2id(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic bit coin(input int pct);
        return ($urandom_range(99) < pct);
    endfunction

    task automatic rand_data();
        for (int i = 0; i < N; i++) begin
            req_prob_p[i*W_P +: W_P]     = W_P'($urandom());
            req_prob_q[i*W_P +: W_P]     = W_P'($urandom());
            req_score[i*W_LOG +: W_LOG]  = W_LOG'($urandom());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL sim_bound: simulation exceeded its time limit");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        int exp_seq [5] = '{0, 1, 2, 3, 0};
        int got_seq [$];
        int exp_pkt [4] = '{1, 1, 1, 2};
        int beats, n;
        bit seen;
        logic [W_P+W_LOG:0] snap;

        rst = 1'b1; out_ready = 1'b1; timeout_cfg = '0;
        req_valid = '0; req_last = '0; req_poison = '0; req_enable = '1;
        req_prob_p = '0; req_prob_q = '0; req_score = '0;
        repeat (2) @(negedge clk);
        model_reset();
        step();
        rst = 1'b0;

        // Round robin over single-beat packets from every requester.
        req_valid = '1; req_last = '1;
        for (int j = 0; j < 5; j++) begin
            rand_data();
            step();
            check("rr_seq", oh2id(acc), exp_seq[j]);
            check("rr_one_per_cycle", $countones(acc), 1);
        end

        // Req1 holds a 3-beat packet while req2 waits.
        req_valid = 4'b0110; beats = 0;
        for (int j = 0; j < 12; j++) begin
            req_last = {1'b0, 1'b1, (beats == 2), 1'b0};
            rand_data();
            step();
            if (acc != '0) got_seq.push_back(oh2id(acc));
            if (acc[1]) beats++;
            if (acc[2]) break;
        end
        req_valid = '0;
        check("pkt_order_len", got_seq.size(), 4);
        for (int j = 0; j < 4; j++)
            if (j < got_seq.size()) check("pkt_order", got_seq[j], exp_pkt[j]);

        // Output stall: slice holds, nothing accepted, release loads at once.
        req_valid = 4'b0001; req_last = '1; rand_data();
        step();
        out_ready = 1'b0;
        snap = {out_prob_p, out_score, out_valid};
        for (int j = 0; j < 5; j++) begin
            rand_data();
            #1;
            check("stall_ready", req_ready, 0);
            check("stall_hold", {out_prob_p, out_score, out_valid}, snap);
            step();
        end
        out_ready = 1'b1;
        #1;
        check("stall_release", req_ready, 4'b0001);
        step();
        req_valid = '0;
        step();

        // Requester 0 stalls mid-packet.
        timeout_cfg = 16'd3;
        req_valid = 4'b0001; req_last = '0; rand_data();
        step();
        check("wd_lock_accept", acc, 4'b0001);
        req_valid = '0;
        seen = 1'b0; n = 0;
        for (int j = 1; j <= 10 && !seen; j++) begin
            step();
            if (out_valid && out_poison) begin
                seen = 1'b1; n = j;
            end
        end
        if (WD_ON) begin
            check("flush_seen", seen, 1);
            check("flush_window", (n >= 3 && n <= 6), 1);
            check("flush_last", out_last, 1);
            check("flush_tuser", out_tuser, 0);
            check("flush_count_one", flush_count, 1);
            step();
            check("flush_to_idle", busy, 0);
        end else begin
            check("no_flush", seen, 0);
            check("still_locked", busy, 1);
            check("flush_count_zero", flush_count, 0);
            req_valid = 4'b0001; req_last = '1;
            step();
            req_valid = '0;
            step();
            check("closed_to_idle", busy, 0);
        end

        // Masked arbitration: only ids 1 and 3 may win.
        req_enable = 4'b1010; req_valid = '1; req_last = '1;
        for (int j = 0; j < 8; j++) begin
            rand_data();
            step();
            check("mask_one", $countones(acc), 1);
            check("mask_ids", acc & 4'b0101, 0);
        end

        // Reset in the middle of a packet abandons it without a flush beat.
        req_enable = 4'b0010; req_valid = 4'b0010; req_last = '0; rand_data();
        step();
        check("rst_pre_busy", busy, 1);
        rst = 1'b1; out_ready = 1'b0;
        step();
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0; out_ready = 1'b1; req_valid = '0; req_enable = '1;
        for (int j = 0; j < 8; j++) begin
            step();
            check("rst_no_flush", (out_valid && out_poison), 0);
        end

        // Randomized traffic against the model.
        for (int blk = 0; blk < 3; blk++) begin
            timeout_cfg = (blk == 0) ? 16'd0 : (blk == 1) ? 16'd2 : 16'd5;
            for (int j = 0; j < 600; j++) begin
                rst = coin(1);
                for (int i = 0; i < N; i++) begin
                    req_valid[i]  = coin(65);
                    req_enable[i] = coin(80);
                    req_last[i]   = coin(40);
                    req_poison[i] = coin(20);
                end
                out_ready = coin(70);
                rand_data();
                step();
            end
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
